// File: rtl/piso_serializer_pkg.sv
// Shared constants for the parallel-to-serial transmitter.
// State encoding is kept as plain localparams so older blocks can reuse it unchanged.
package piso_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/piso_shift_cell.sv
// One stage of the serializer shift register: parallel load has priority over shift.
module piso_shift_cell (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic shift,
    input  logic load_bit,
    input  logic shift_bit,
    output logic q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (load) begin
            q <= load_bit;
        end else if (shift) begin
            q <= shift_bit;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-to-serial transmitter: accepts a word on a valid/ready handshake and
// shifts it out one bit per clock with a frame marker and a last-bit done pulse.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sreg;
    logic             last_bit;
    logic             accept;
    logic             shifting;

    assign last_bit   = (state == ST_SHIFT) && (count == LAST);
    assign load_ready = (state == ST_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;
    assign shifting   = (state == ST_SHIFT);
    assign frame      = (state == ST_SHIFT);

    // Done is registered one cycle ahead so it lines up with the last bit on the wire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else if (accept) begin
            state <= ST_SHIFT;
            count <= '0;
            done  <= 1'b0;
        end else if (state == ST_SHIFT) begin
            if (last_bit) begin
                state <= ST_IDLE;
                count <= '0;
                done  <= 1'b0;
            end else begin
                count <= count + 1'b1;
                done  <= (count == PENULT);
            end
        end
    end

    // Zeros are shifted in, so the register is empty (and the line low) once a word drains.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shift_bit;

        if (LSB_FIRST) begin : g_lsb
            if (i == WIDTH - 1) begin : g_end
                assign shift_bit = 1'b0;
            end else begin : g_mid
                assign shift_bit = sreg[i+1];
            end
        end else begin : g_msb
            if (i == 0) begin : g_end
                assign shift_bit = 1'b0;
            end else begin : g_mid
                assign shift_bit = sreg[i-1];
            end
        end

        piso_shift_cell u_cell (
            .clock     (clock),
            .reset     (reset),
            .load      (accept),
            .shift     (shifting),
            .load_bit  (data_in[i]),
            .shift_bit (shift_bit),
            .q         (sreg[i])
        );
    end

    if (LSB_FIRST) begin : g_out_lsb
        assign serial_out = sreg[0];
    end else begin : g_out_msb
        assign serial_out = sreg[WIDTH-1];
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: drives an LSB-first and an MSB-first serializer from one source
// and compares every cycle against a bit-queue model of the expected wire traffic.
module tb_piso_serializer;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic last;
    } bit_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load_valid = 1'b0;

    logic lrL, soL, frL, dnL;
    logic lrM, soM, frM, dnM;

    bit_t         qL[$];
    bit_t         qM[$];
    bit_t         curL;
    bit_t         curM;
    bit           curValid = 1'b0;
    logic [W-1:0] srcQ[$];
    bit           offering = 1'b0;
    int           gapPct = 0;

    int asserts  = 0;
    int failures = 0;

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (lrL),
        .serial_out (soL),
        .frame      (frL),
        .done       (dnL)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (lrM),
        .serial_out (soM),
        .frame      (frM),
        .done       (dnM)
    );

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        asserts++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // A word stays offered until it is taken; gaps are only inserted before a fresh word.
    task automatic applyStimulus();
        if (srcQ.size() > 0 && (offering || $urandom_range(99) >= gapPct)) begin
            offering   = 1'b1;
            load_valid = 1'b1;
            data_in    = srcQ[0];
        end else begin
            load_valid = 1'b0;
            data_in    = W'($urandom);
        end
    endtask

    task automatic stepCycle();
        bit           ready;
        bit           acc;
        logic [W-1:0] w;
        logic         expSo;
        logic         expFr;
        logic         expDn;
        applyStimulus();
        #1;
        ready = !curValid || curL.last;
        checkOutput("load_ready_lsb", lrL, ready);
        checkOutput("load_ready_msb", lrM, ready);
        acc = load_valid && ready;
        @(posedge clock);
        if (acc) begin
            w = srcQ.pop_front();
            offering = 1'b0;
            for (int i = 0; i < W; i++) begin
                qL.push_back('{b: w[i],       last: (i == W - 1)});
                qM.push_back('{b: w[W-1-i],   last: (i == W - 1)});
            end
        end
        if (qL.size() > 0) begin
            curL     = qL.pop_front();
            curM     = qM.pop_front();
            curValid = 1'b1;
        end else begin
            curValid = 1'b0;
        end
        #1;
        expFr = curValid;
        expSo = curValid ? curL.b : 1'b0;
        expDn = curValid ? curL.last : 1'b0;
        checkOutput("serial_lsb", soL, expSo);
        checkOutput("frame_lsb",  frL, expFr);
        checkOutput("done_lsb",   dnL, expDn);
        expSo = curValid ? curM.b : 1'b0;
        expDn = curValid ? curM.last : 1'b0;
        checkOutput("serial_msb", soM, expSo);
        checkOutput("frame_msb",  frM, expFr);
        checkOutput("done_msb",   dnM, expDn);
        @(negedge clock);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    // Reset lands between edges, so the outputs must fall without any clock.
    task automatic pulseReset();
        #3;
        reset      = 1'b1;
        load_valid = 1'b0;
        #1;
        checkOutput("rst_serial_lsb", soL, 1'b0);
        checkOutput("rst_frame_lsb",  frL, 1'b0);
        checkOutput("rst_done_lsb",   dnL, 1'b0);
        checkOutput("rst_serial_msb", soM, 1'b0);
        checkOutput("rst_frame_msb",  frM, 1'b0);
        checkOutput("rst_done_msb",   dnM, 1'b0);
        qL.delete();
        qM.delete();
        srcQ.delete();
        curValid = 1'b0;
        offering = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rel_ready_lsb", lrL, 1'b1);
        checkOutput("rel_frame_lsb", frL, 1'b0);
        checkOutput("rel_ready_msb", lrM, 1'b1);
        checkOutput("rel_frame_msb", frM, 1'b0);
    endtask

    initial begin
        $display("[TB] start");
        pulseReset();

        $display("[TB] single word 8'hC1");
        srcQ.push_back(8'hC1);
        runCycles(10);

        $display("[TB] back-to-back 8'hC1 then 8'h3C");
        srcQ.push_back(8'hC1);
        srcQ.push_back(8'h3C);
        runCycles(18);

        $display("[TB] valid held while busy");
        srcQ.push_back(8'hA5);
        runCycles(2);
        srcQ.push_back(8'h5A);
        runCycles(18);

        $display("[TB] reset during 8'hFF, then 8'h01");
        srcQ.push_back(8'hFF);
        runCycles(3);
        pulseReset();
        srcQ.push_back(8'h01);
        runCycles(10);

        $display("[TB] random traffic");
        gapPct = 30;
        for (int c = 0; c < 400; c++) begin
            if (srcQ.size() < 2 && $urandom_range(1) == 1) srcQ.push_back(W'($urandom));
            stepCycle();
        end
        runCycles(30);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
